fu_operand_regfile: RTL

- Register file and write-back stage that sits directly upstream of the function unit.
- Supplies the A and B operands (a_out -> FU a_in, b_out -> FU b_in) and captures the FU result f_out, or memory load data, back into a destination register.
- Latches the FU zero/negative outputs into a status register that the control unit uses for branches.
- Includes constant-B muxing and write-through bypass, so a result written this cycle is visible on the operand outputs in the same cycle.

---
 rtl/fu_operand_regfile_if.sv | 40 ++++
 rtl/fu_operand_regfile.sv | 72 +++++++
 2 files changed

// File: rtl/fu_operand_regfile_if.sv
// Operand/write-back bus between the control path and the FU operand register file.
// Inputs are sampled on the rising clock. Outputs are combinational, except the flags and write count. There is no backpressure.
interface fu_operand_regfile_if #(
  parameter int NREG  = 8,
  parameter int WIDTH = 16
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [AW-1:0]    aa_in;
  logic [AW-1:0]    ba_in;
  logic             mb_in;
  logic [WIDTH-1:0] const_in;
  logic [AW-1:0]    da_in;
  logic             rw_in;
  logic             md_in;
  logic [WIDTH-1:0] f_in;
  logic [WIDTH-1:0] data_in;
  logic             z_in;
  logic             n_in;
  logic             fl_we_in;
  logic             fl_clr_in;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] data_out;
  logic             z_flag;
  logic             n_flag;
  logic [7:0]       wr_cnt;

  modport master (
    output aa_in, ba_in, mb_in, const_in, da_in, rw_in, md_in,
           f_in, data_in, z_in, n_in, fl_we_in, fl_clr_in,
    input  a_out, b_out, data_out, z_flag, n_flag, wr_cnt
  );

  modport slave (
    input  aa_in, ba_in, mb_in, const_in, da_in, rw_in, md_in,
           f_in, data_in, z_in, n_in, fl_we_in, fl_clr_in,
    output a_out, b_out, data_out, z_flag, n_flag, wr_cnt
  );
endinterface

// File: rtl/fu_operand_regfile.sv
// Register file feeding FU operands. Reads are 0-cycle with write-through bypass, and flags have 1-cycle latency.
// There is no backpressure: one write per clock, and a write is always accepted.
module fu_operand_regfile #(
  parameter int NREG  = 8,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fu_operand_regfile_if.slave   bus
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [WIDTH-1:0] r_regs [NREG];
  logic             r_z;
  logic             r_n;
  logic [7:0]       r_wr_cnt;

  logic [WIDTH-1:0] w_wd;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_reg_b;

  assign w_wd = bus.md_in ? bus.data_in : bus.f_in;
  // A write held in reset never lands, so it must not bypass onto the read ports.
  assign w_wr_en = bus.rw_in & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.rw_in) begin
      r_regs[bus.da_in] <= w_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
    end else if (bus.fl_clr_in) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
    end else if (bus.fl_we_in) begin
      r_z <= bus.z_in;
      r_n <= bus.n_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= 8'd0;
    end else if (bus.rw_in && (r_wr_cnt != 8'hFF)) begin
      r_wr_cnt <= r_wr_cnt + 8'd1;
    end
  end

  assign bus.a_out    = (w_wr_en && (bus.da_in == bus.aa_in)) ? w_wd : r_regs[bus.aa_in];
  assign w_reg_b      = (w_wr_en && (bus.da_in == bus.ba_in)) ? w_wd : r_regs[bus.ba_in];
  assign bus.b_out    = bus.mb_in ? bus.const_in : w_reg_b;
  assign bus.data_out = w_reg_b;
  assign bus.z_flag   = r_z;
  assign bus.n_flag   = r_n;
  assign bus.wr_cnt   = r_wr_cnt;

  // Bypassing FU output back into its own operand forms a combinational loop.
  a_no_fu_loop: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rw_in && !bus.md_in) |->
      ((bus.da_in != bus.aa_in) && (bus.mb_in || (bus.da_in != bus.ba_in))));

  logic [AW-1:0] w_unused_aw;
  assign w_unused_aw = '0;
endmodule
